instr_fetch_decode: RTL and testbench
=====================================

INSTR_FETCH_DECODE -- requirements
Module: instr_fetch_decode

Interface
REQ-001 SHALL have parameter PC_RESET, default 32'h0000_0000, meaning the PC value loaded at reset.
REQ-002 SHALL have parameter HALT_OP, default 6'h3F, meaning the opcode that stops fetching.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begin fetching from IDLE.
REQ-006 SHALL have port mem_req  output  1  instruction-memory read request.
REQ-007 SHALL have port mem_addr  output  32  read address, equal to pc.
REQ-008 SHALL have port mem_ack  input  1  mem_rdata valid this cycle.
REQ-009 SHALL have port mem_rdata  input  32  instruction word.
REQ-010 SHALL have port stall  input  1  downstream hold request.
REQ-011 SHALL have port branch_taken  input  1  redirect the PC when the issued instruction retires.
REQ-012 SHALL have port branch_target  input  32  redirect address.
REQ-013 SHALL have port pc  output  32  address of the current or issued instruction.
REQ-014 SHALL have port ir  output  32  latched instruction word.
REQ-015 SHALL have port imm  output  16  ir[15:0], feeding the immediate-extension stage input a.
REQ-016 SHALL have port sext  output  1  1 = sign-extend and 0 = zero-extend, feeding the extension stage.
REQ-017 SHALL have port out_valid  output  1  ir, imm and sext valid (ISSUE state).
REQ-018 SHALL have port halted  output  1  HALT state reached.

Function
REQ-019 SHALL implement FSM states IDLE, FETCH, ISSUE and HALT.
REQ-020 SHALL transition IDLE->FETCH when start=1, and otherwise remain in IDLE.
REQ-021 SHALL, in FETCH, hold mem_req=1 and mem_addr=pc every cycle until mem_ack=1, with no timeout.
REQ-022 SHALL, on mem_ack in FETCH, latch ir<=mem_rdata, imm<=mem_rdata[15:0] and sext<=f(opcode), then go to ISSUE, giving 1-cycle latency from ack to out_valid.
REQ-023 SHALL define sext=0 for opcodes 6'h00, 6'h0C (andi), 6'h0D (ori), 6'h0E (xori) and 6'h0F (lui), and sext=1 for all other opcodes.
REQ-024 SHALL, in ISSUE, hold out_valid=1 and keep ir, imm, sext and pc stable while stall=1.
REQ-025 SHALL, in ISSUE with stall=0, retire the instruction: pc<=branch_taken ? {branch_target[31:2],2'b00} : pc+4.
REQ-026 SHALL, on retire, go to HALT if ir[31:26]==HALT_OP, else to FETCH.
REQ-027 SHALL use 32-bit wrapping arithmetic for pc, so 32'hFFFF_FFFC+4 gives 32'h0000_0000.
REQ-028 SHALL ignore branch_taken outside a retiring ISSUE cycle.
REQ-029 SHALL ignore mem_ack outside FETCH.
REQ-030 SHALL ignore start outside IDLE.
REQ-031 SHALL keep HALT sticky (halted=1, mem_req=0) until rst.
REQ-032 SHALL apply stall priority over branch_taken, so a stalled cycle changes nothing.

Reset
REQ-033 SHALL, on rst=1 regardless of clk, force state=IDLE, pc=PC_RESET, ir=0, imm=0, sext=0, mem_req=0, out_valid=0 and halted=0.
REQ-034 SHALL, on reset asserted mid-FETCH, drop mem_req in the same cycle and discard any later mem_ack.
REQ-035 SHALL resume only via start after reset deassertion.

Structure
REQ-036 SHALL place the state encoding, opcode constants (ANDI, ORI, XORI, LUI, HALT_OP default) and PC_STEP=4 in a shared package.
REQ-037 SHALL place the opcode-to-sext decode in one combinational sub-module, sext_decode, reusable by the datapath control.

Verification
REQ-038 SHALL verify that reset followed by start=1 gives mem_req=1 and mem_addr=32'h0 on the next cycle, with pc=0 and out_valid=0.
REQ-039 SHALL verify that ack with mem_rdata=32'h3C01_8000 (lui) gives, after 1 cycle, out_valid=1, imm=16'h8000 and sext=0; then 32'h2001_FFFF (addi) gives imm=16'hFFFF and sext=1.
REQ-040 SHALL verify that mem_ack delayed 3 cycles keeps mem_req=1 and mem_addr stable for 3 cycles, and that stall=1 for 4 cycles in ISSUE keeps ir and pc unchanged, with pc+4 on release.
REQ-041 SHALL verify that ISSUE with branch_taken=1 and branch_target=32'h0000_0103 gives next mem_addr=32'h0000_0100.
REQ-042 SHALL verify that fetching 32'hFC00_0000 (HALT_OP) gives halted=1 and mem_req=0 after retire, with start ignored.
REQ-043 SHALL verify that rst=1 mid-FETCH clears mem_req asynchronously, a later mem_ack leaves ir=0, and pc wraps correctly when PC_RESET=32'hFFFF_FFFC.

Source files
------------

// File: rtl/instr_fetch_decode_pkg.sv
// Shared definitions for the instruction fetch/decode slice: FSM state
// encoding, opcode constants and the PC step size.
package instr_fetch_decode_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam logic [5:0] OP_ZERO         = 6'h00;
  localparam logic [5:0] OP_ANDI         = 6'h0C;
  localparam logic [5:0] OP_ORI          = 6'h0D;
  localparam logic [5:0] OP_XORI         = 6'h0E;
  localparam logic [5:0] OP_LUI          = 6'h0F;
  localparam logic [5:0] OP_HALT_DEFAULT = 6'h3F;

  localparam logic [31:0] PC_STEP = 32'd4;

  // Branch targets are forced onto a word boundary before loading the PC.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_decode_sext_decode.sv
// Opcode-to-extension-mode decode: logical immediates and lui take a
// zero-extended immediate, everything else is sign-extended.
module sext_decode
  import instr_fetch_decode_pkg::*;
(
  input  logic [5:0] opcode,
  output logic       sext
);

  // Pure lookup on the opcode field; no state.
  always_comb begin
    sext = 1'b1;
    case (opcode)
      OP_ZERO, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: sext = 1'b0;
      default:                                   sext = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_fetch_decode.sv
// Instruction fetch/decode front end: requests a word from instruction
// memory, latches it with its immediate and extension mode, presents it
// downstream until it retires, then advances or redirects the PC.
module instr_fetch_decode
  import instr_fetch_decode_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP  = OP_HALT_DEFAULT
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic [15:0] imm,
  output logic        sext,
  output logic        out_valid,
  output logic        halted
);

  state_t state;
  logic   sext_next;

  sext_decode u_sext_decode (
    .opcode (mem_rdata[31:26]),
    .sext   (sext_next)
  );

  assign mem_addr = pc;

  // Fetch/issue sequencer with all outputs registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      pc        <= PC_RESET;
      ir        <= 32'h0;
      imm       <= 16'h0;
      sext      <= 1'b0;
      mem_req   <= 1'b0;
      out_valid <= 1'b0;
      halted    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_FETCH;
            mem_req <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (mem_ack) begin
            ir        <= mem_rdata;
            imm       <= mem_rdata[15:0];
            sext      <= sext_next;
            mem_req   <= 1'b0;
            out_valid <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!stall) begin
            pc        <= branch_taken ? align_word(branch_target) : pc + PC_STEP;
            out_valid <= 1'b0;
            if (ir[31:26] == HALT_OP) begin
              state  <= ST_HALT;
              halted <= 1'b1;
            end else begin
              state   <= ST_FETCH;
              mem_req <= 1'b1;
            end
          end
        end
        ST_HALT: begin
          halted  <= 1'b1;
          mem_req <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed bench for instr_fetch_decode: a default instance plus one with
// PC_RESET at the top of the address space, sharing all inputs.
module tb_instr_fetch_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;

  logic        mem_req0, out_valid0, halted0, sext0;
  logic [31:0] mem_addr0, pc0, ir0;
  logic [15:0] imm0;

  logic        mem_req1, out_valid1, halted1, sext1;
  logic [31:0] mem_addr1, pc1, ir1;
  logic [15:0] imm1;

  int checkCount = 0;
  int passCount  = 0;

  instr_fetch_decode dut0 (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .mem_req       (mem_req0),
    .mem_addr      (mem_addr0),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc            (pc0),
    .ir            (ir0),
    .imm           (imm0),
    .sext          (sext0),
    .out_valid     (out_valid0),
    .halted        (halted0)
  );

  instr_fetch_decode #(.PC_RESET(32'hFFFF_FFFC)) dut1 (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .mem_req       (mem_req1),
    .mem_addr      (mem_addr1),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc            (pc1),
    .ir            (ir1),
    .imm           (imm1),
    .sext          (sext1),
    .out_valid     (out_valid1),
    .halted        (halted1)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic s, input logic ack, input logic [31:0] rdata,
                               input logic stl, input logic bt, input logic [31:0] tgt);
    start         = s;
    mem_ack       = ack;
    mem_rdata     = rdata;
    stall         = stl;
    branch_taken  = bt;
    branch_target = tgt;
  endtask

  // Advance to just after the next rising edge; inputs and samples live here.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Directed sequence with hand-computed expectations.
  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    stepCycle();
    checkOutput("rst_mem_req",   32'(mem_req0),   32'h0);
    checkOutput("rst_pc",        pc0,             32'h0);
    checkOutput("rst_out_valid", 32'(out_valid0), 32'h0);
    checkOutput("rst_halted",    32'(halted0),    32'h0);
    checkOutput("rst_ir",        ir0,             32'h0);
    checkOutput("rst_pc_hi",     pc1,             32'hFFFF_FFFC);
    rst = 1'b0;
    stepCycle();
    checkOutput("idle_no_req", 32'(mem_req0), 32'h0);

    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    stepCycle();
    start = 1'b0;
    checkOutput("start_mem_req",   32'(mem_req0),   32'h1);
    checkOutput("start_mem_addr",  mem_addr0,       32'h0);
    checkOutput("start_pc",        pc0,             32'h0);
    checkOutput("start_out_valid", 32'(out_valid0), 32'h0);

    applyStimulus(1'b0, 1'b1, 32'h3C01_8000, 1'b0, 1'b0, 32'h0);
    stepCycle();
    mem_ack = 1'b0;
    checkOutput("lui_out_valid", 32'(out_valid0), 32'h1);
    checkOutput("lui_imm",       32'(imm0),       32'h8000);
    checkOutput("lui_sext",      32'(sext0),      32'h0);
    checkOutput("lui_ir",        ir0,             32'h3C01_8000);
    checkOutput("lui_mem_req",   32'(mem_req0),   32'h0);
    stepCycle();
    checkOutput("lui_retire_pc",  pc0,            32'h4);
    checkOutput("lui_retire_req", 32'(mem_req0),  32'h1);

    applyStimulus(1'b0, 1'b1, 32'h2001_FFFF, 1'b0, 1'b0, 32'h0);
    stepCycle();
    checkOutput("addi_imm",  32'(imm0),  32'hFFFF);
    checkOutput("addi_sext", 32'(sext0), 32'h1);
    applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h0000_0200);
    for (int i = 0; i < 4; i++) begin
      stepCycle();
      checkOutput($sformatf("stall_ir_%0d", i),    ir0,             32'h2001_FFFF);
      checkOutput($sformatf("stall_pc_%0d", i),    pc0,             32'h4);
      checkOutput($sformatf("stall_valid_%0d", i), 32'(out_valid0), 32'h1);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    stepCycle();
    checkOutput("release_pc",      pc0,            32'h8);
    checkOutput("release_mem_req", 32'(mem_req0),  32'h1);

    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0300);
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput($sformatf("wait_req_%0d", i),  32'(mem_req0), 32'h1);
      checkOutput($sformatf("wait_addr_%0d", i), mem_addr0,     32'h8);
    end
    applyStimulus(1'b0, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 32'h0);
    stepCycle();
    checkOutput("op0_sext", 32'(sext0), 32'h0);
    checkOutput("op0_ir",   ir0,        32'h0000_0001);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0103);
    stepCycle();
    checkOutput("branch_addr", mem_addr0, 32'h0000_0100);

    applyStimulus(1'b0, 1'b1, 32'hFC00_0000, 1'b0, 1'b0, 32'h0);
    stepCycle();
    mem_ack = 1'b0;
    checkOutput("halt_issue_valid", 32'(out_valid0), 32'h1);
    checkOutput("halt_issue_sext",  32'(sext0),      32'h1);
    stepCycle();
    checkOutput("halt_halted",  32'(halted0),  32'h1);
    checkOutput("halt_mem_req", 32'(mem_req0), 32'h0);
    checkOutput("halt_pc",      pc0,           32'h0000_0104);
    start = 1'b1;
    stepCycle();
    stepCycle();
    start = 1'b0;
    checkOutput("halt_sticky",       32'(halted0),  32'h1);
    checkOutput("halt_start_no_req", 32'(mem_req0), 32'h0);

    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    checkOutput("rerst_halted", 32'(halted0), 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    stepCycle();
    start = 1'b0;
    checkOutput("refetch_req",     32'(mem_req0), 32'h1);
    checkOutput("refetch_addr_hi", mem_addr1,     32'hFFFF_FFFC);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_req0", 32'(mem_req0), 32'h0);
    checkOutput("async_req1", 32'(mem_req1), 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h2001_1234, 1'b0, 1'b0, 32'h0);
    stepCycle();
    rst = 1'b0;
    stepCycle();
    mem_ack = 1'b0;
    checkOutput("late_ack_ir",    ir0,              32'h0);
    checkOutput("late_ack_valid", 32'(out_valid0),  32'h0);
    checkOutput("late_ack_req",   32'(mem_req0),    32'h0);

    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    stepCycle();
    start = 1'b0;
    checkOutput("wrap_fetch_addr", mem_addr1, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b1, 32'h2001_0000, 1'b0, 1'b0, 32'h0);
    stepCycle();
    mem_ack = 1'b0;
    checkOutput("wrap_valid", 32'(out_valid1), 32'h1);
    stepCycle();
    checkOutput("wrap_pc",   pc1,            32'h0);
    checkOutput("wrap_addr", mem_addr1,      32'h0);
    checkOutput("wrap_req",  32'(mem_req1),  32'h1);
    checkOutput("nowrap_pc", pc0,            32'h4);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
